// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: fetch/pipeline-status bundle seen by the PC sequencer and hazard controller.
// master = pipeline side (drives status, reads controls); slave = pc_ctrl.
interface pc_ctrl_if;
  localparam int unsigned XLEN = 64;
  localparam int unsigned CNTW = 32;

  logic [3:0]      f_icode;
  logic [XLEN-1:0] f_valc;
  logic [XLEN-1:0] f_valp;
  logic            f_instr_valid;
  logic            f_error;
  logic [3:0]      d_srcA;
  logic [3:0]      d_srcB;
  logic [3:0]      D_icode;
  logic [3:0]      E_icode;
  logic [3:0]      M_icode;
  logic [3:0]      W_icode;
  logic [3:0]      E_dstM;
  logic            e_cnd;
  logic            M_cnd;
  logic [XLEN-1:0] M_valA;
  logic [XLEN-1:0] W_valM;
  logic [1:0]      W_stat;

  logic [XLEN-1:0] pc;
  logic            F_stall;
  logic            D_stall;
  logic            D_bubble;
  logic            E_bubble;
  logic            halted;
  logic [CNTW-1:0] cyc_cnt;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] mispred_cnt;

  modport master (
    output f_icode, f_valc, f_valp, f_instr_valid, f_error,
    output d_srcA, d_srcB, D_icode, E_icode, M_icode, W_icode, E_dstM,
    output e_cnd, M_cnd, M_valA, W_valM, W_stat,
    input  pc, F_stall, D_stall, D_bubble, E_bubble, halted,
    input  cyc_cnt, stall_cnt, mispred_cnt
  );

  modport slave (
    input  f_icode, f_valc, f_valp, f_instr_valid, f_error,
    input  d_srcA, d_srcB, D_icode, E_icode, M_icode, W_icode, E_dstM,
    input  e_cnd, M_cnd, M_valA, W_valM, W_stat,
    output pc, F_stall, D_stall, D_bubble, E_bubble, halted,
    output cyc_cnt, stall_cnt, mispred_cnt
  );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: Y86-64 fetch-stage PC sequencer, hazard controller and RUN/DRAIN/HALT status FSM.
// Optional performance counters are built when PC_CTRL_PERF_EN is defined; otherwise
// the counter outputs are tied to zero and no counter flops exist.
module pc_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic      clk,
  input  logic      rst_n,
  pc_ctrl_if.slave  bus
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned CNTW = 32;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pred_pc_q, pred_pc_d;
  logic            load_use, ret_p, mispred, fstop;
  logic            f_stall, d_stall, d_bubble, e_bubble;

  // Hazard detection terms
  always_comb begin
    load_use = ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
               (bus.E_dstM != R_NONE) &&
               ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    ret_p    = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) || (bus.M_icode == I_RET);
    mispred  = (bus.E_icode == I_JXX) && !bus.e_cnd;
    fstop    = (bus.f_icode == I_HALT) || !bus.f_instr_valid || bus.f_error;
  end

  // Status FSM next state and pipeline control outputs
  always_comb begin
    state_d  = state_q;
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    d_bubble = 1'b0;
    e_bubble = 1'b0;

    if (state_q == S_HALT) begin
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_bubble = 1'b1;
    end else begin
      f_stall  = load_use | ret_p | (state_q != S_RUN);
      d_stall  = load_use;
      d_bubble = mispred | (ret_p & !load_use) | ((state_q == S_DRAIN) & !load_use);
      e_bubble = mispred | load_use;
    end

    unique case (state_q)
      S_RUN: begin
        if (bus.W_stat != 2'd0)                  state_d = S_HALT;
        else if (fstop && !f_stall && !mispred)  state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // a stop instruction fetched down a mispredicted path must not halt the core
        if (bus.W_stat != 2'd0)                  state_d = S_HALT;
        else if (mispred)                        state_d = S_RUN;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  // Next-PC prediction and fetch PC select
  always_comb begin
    pred_pc_d = pred_pc_q;
    if (!f_stall) begin
      pred_pc_d = ((bus.f_icode == I_JXX) || (bus.f_icode == I_CALL)) ? bus.f_valc : bus.f_valp;
    end

    if ((bus.M_icode == I_JXX) && !bus.M_cnd) bus.pc = bus.M_valA;
    else if (bus.W_icode == I_RET)            bus.pc = bus.W_valM;
    else                                      bus.pc = pred_pc_q;
  end

  // State and predicted-PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RUN;
      pred_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pred_pc_q <= pred_pc_d;
    end
  end

  assign bus.F_stall  = f_stall;
  assign bus.D_stall  = d_stall;
  assign bus.D_bubble = d_bubble;
  assign bus.E_bubble = e_bubble;
  assign bus.halted   = (state_q == S_HALT);

`ifdef PC_CTRL_PERF_EN
  logic [CNTW-1:0] cyc_cnt_q, stall_cnt_q, mispred_cnt_q;

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q     <= '0;
      stall_cnt_q   <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if ((state_q != S_HALT) && (cyc_cnt_q != '1))
        cyc_cnt_q <= cyc_cnt_q + CNTW'(1);
      if ((state_q != S_HALT) && f_stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNTW'(1);
      if (mispred && (mispred_cnt_q != '1))
        mispred_cnt_q <= mispred_cnt_q + CNTW'(1);
    end
  end

  assign bus.cyc_cnt     = cyc_cnt_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;
`else
  assign bus.cyc_cnt     = '0;
  assign bus.stall_cnt   = '0;
  assign bus.mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed test-plan sequence followed by random pipeline status, all checked
// through a scoreboard fed by a behavioural model of the PC/hazard/status rules.
module tb_pc_ctrl;

  localparam logic [63:0] RST_PC = 64'h100;
  localparam int MODE_RUN   = 0;
  localparam int MODE_DRAIN = 1;
  localparam int MODE_HALT  = 2;
`ifdef PC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_ctrl_if ifc();
  pc_ctrl #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  typedef struct {
    logic [3:0]  f_icode;
    logic [63:0] f_valc, f_valp;
    logic        f_instr_valid, f_error;
    logic [3:0]  d_srcA, d_srcB, D_icode, E_icode, M_icode, W_icode, E_dstM;
    logic        e_cnd, M_cnd;
    logic [63:0] M_valA, W_valM;
    logic [1:0]  W_stat;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic        f_stall, d_stall, d_bubble, e_bubble, halted;
    logic [31:0] cyc, stl, mis;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model state
  logic [63:0] m_pred;
  int          m_mode;
  logic [31:0] m_cyc, m_stl, m_mis;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic vec_t idle_vec();
    vec_t v;
    v.f_icode = 4'h1; v.f_valc = 64'h0; v.f_valp = 64'h0;
    v.f_instr_valid = 1'b1; v.f_error = 1'b0;
    v.d_srcA = 4'hF; v.d_srcB = 4'hF;
    v.D_icode = 4'h1; v.E_icode = 4'h1; v.M_icode = 4'h1; v.W_icode = 4'h1;
    v.E_dstM = 4'hF; v.e_cnd = 1'b1; v.M_cnd = 1'b1;
    v.M_valA = 64'h0; v.W_valM = 64'h0; v.W_stat = 2'd0;
    return v;
  endfunction

  function automatic logic [3:0] rand_reg();
    return ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.f_icode = ($urandom_range(0, 24) == 0) ? 4'h0 : 4'($urandom_range(1, 11));
    v.f_valc = {$urandom(), $urandom()};
    v.f_valp = {$urandom(), $urandom()};
    v.f_instr_valid = ($urandom_range(0, 29) != 0);
    v.f_error = ($urandom_range(0, 39) == 0);
    v.d_srcA = rand_reg(); v.d_srcB = rand_reg(); v.E_dstM = rand_reg();
    v.D_icode = 4'($urandom_range(0, 11)); v.E_icode = 4'($urandom_range(0, 11));
    v.M_icode = 4'($urandom_range(0, 11)); v.W_icode = 4'($urandom_range(0, 11));
    v.e_cnd = $urandom_range(0, 1) != 0; v.M_cnd = $urandom_range(0, 1) != 0;
    v.M_valA = {$urandom(), $urandom()};
    v.W_valM = {$urandom(), $urandom()};
    v.W_stat = ($urandom_range(0, 79) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ifc.f_icode = v.f_icode; ifc.f_valc = v.f_valc; ifc.f_valp = v.f_valp;
    ifc.f_instr_valid = v.f_instr_valid; ifc.f_error = v.f_error;
    ifc.d_srcA = v.d_srcA; ifc.d_srcB = v.d_srcB;
    ifc.D_icode = v.D_icode; ifc.E_icode = v.E_icode; ifc.M_icode = v.M_icode;
    ifc.W_icode = v.W_icode; ifc.E_dstM = v.E_dstM;
    ifc.e_cnd = v.e_cnd; ifc.M_cnd = v.M_cnd;
    ifc.M_valA = v.M_valA; ifc.W_valM = v.W_valM; ifc.W_stat = v.W_stat;
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  // Expected outputs for this cycle from the model, then advance the model across the next edge
  task automatic model(input vec_t v, input bit rst, output exp_t e);
    bit lu, rp, mp, stop;
    if (rst) begin
      m_pred = RST_PC; m_mode = MODE_RUN; m_cyc = 0; m_stl = 0; m_mis = 0;
    end
    lu   = (v.E_icode == 4'h5 || v.E_icode == 4'hB) && v.E_dstM != 4'hF &&
           (v.E_dstM == v.d_srcA || v.E_dstM == v.d_srcB);
    rp   = (v.D_icode == 4'h9) || (v.E_icode == 4'h9) || (v.M_icode == 4'h9);
    mp   = (v.E_icode == 4'h7) && !v.e_cnd;
    stop = (v.f_icode == 4'h0) || !v.f_instr_valid || v.f_error;

    if (v.M_icode == 4'h7 && !v.M_cnd) e.pc = v.M_valA;
    else if (v.W_icode == 4'h9)        e.pc = v.W_valM;
    else                               e.pc = m_pred;

    if (m_mode == MODE_HALT) begin
      e.f_stall = 1; e.d_stall = 1; e.d_bubble = 0; e.e_bubble = 1;
    end else begin
      e.f_stall  = lu || rp || (m_mode != MODE_RUN);
      e.d_stall  = lu;
      e.d_bubble = mp || (rp && !lu) || (m_mode == MODE_DRAIN && !lu);
      e.e_bubble = mp || lu;
    end
    e.halted = (m_mode == MODE_HALT);
    e.cyc = PERF ? m_cyc : 32'd0;
    e.stl = PERF ? m_stl : 32'd0;
    e.mis = PERF ? m_mis : 32'd0;

    if (!rst) begin
      if (m_mode != MODE_HALT) m_cyc = sat_inc(m_cyc);
      if (m_mode != MODE_HALT && e.f_stall) m_stl = sat_inc(m_stl);
      if (mp) m_mis = sat_inc(m_mis);
      if (!e.f_stall) m_pred = (v.f_icode == 4'h7 || v.f_icode == 4'h8) ? v.f_valc : v.f_valp;
      if (m_mode != MODE_HALT && v.W_stat != 2'd0)              m_mode = MODE_HALT;
      else if (m_mode == MODE_RUN && stop && !e.f_stall && !mp) m_mode = MODE_DRAIN;
      else if (m_mode == MODE_DRAIN && mp)                      m_mode = MODE_RUN;
    end
  endtask

  // One clock of stimulus: drive just after the edge, push the expectation
  task automatic step(input vec_t v, input bit rst);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = !rst;
    drive(v);
    model(v, rst, e);
    sb.push_back(e);
  endtask

  // Monitor: compare every presented cycle against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      cmp("pc",          ifc.pc,                 e.pc);
      cmp("F_stall",     64'(ifc.F_stall),       64'(e.f_stall));
      cmp("D_stall",     64'(ifc.D_stall),       64'(e.d_stall));
      cmp("D_bubble",    64'(ifc.D_bubble),      64'(e.d_bubble));
      cmp("E_bubble",    64'(ifc.E_bubble),      64'(e.e_bubble));
      cmp("halted",      64'(ifc.halted),        64'(e.halted));
      cmp("cyc_cnt",     64'(ifc.cyc_cnt),       64'(e.cyc));
      cmp("stall_cnt",   64'(ifc.stall_cnt),     64'(e.stl));
      cmp("mispred_cnt", 64'(ifc.mispred_cnt),   64'(e.mis));
    end
  end

  initial begin
    vec_t v;
    drive(idle_vec());

    // reset, nop fetch
    step(idle_vec(), 1); step(idle_vec(), 1);
    v = idle_vec(); v.f_valp = 64'h101;
    step(v, 0); #1 cmp("lit_reset_pc", ifc.pc, 64'h100);
    // taken jXX predicted to valC
    v = idle_vec(); v.f_icode = 4'h7; v.f_valc = 64'h40; v.f_valp = 64'h10A;
    step(v, 0); #1 cmp("lit_nop_pc", ifc.pc, 64'h101);
    v = idle_vec(); v.f_valp = 64'h49;
    step(v, 0); #1 cmp("lit_jxx_pc", ifc.pc, 64'h40);
    v = idle_vec(); v.E_icode = 4'h7; v.e_cnd = 1'b0;
    step(v, 0); #1 cmp("lit_mispred_dbub", 64'(ifc.D_bubble & ifc.E_bubble), 64'd1);
    v = idle_vec(); v.M_icode = 4'h7; v.M_cnd = 1'b0; v.M_valA = 64'h109;
    step(v, 0); #1 cmp("lit_mispred_pc", ifc.pc, 64'h109);
    // load-use for a single cycle
    v = idle_vec(); v.E_icode = 4'h5; v.E_dstM = 4'h3; v.d_srcA = 4'h3;
    step(v, 0); #1 cmp("lit_loaduse", 64'({ifc.F_stall, ifc.D_stall, ifc.E_bubble}), 64'd7);
    step(idle_vec(), 0); #1 cmp("lit_loaduse_end", 64'(ifc.F_stall), 64'd0);
    // ret moving down D, E, M, then W supplies the return address
    v = idle_vec(); v.D_icode = 4'h9; step(v, 0);
    v = idle_vec(); v.E_icode = 4'h9; step(v, 0);
    v = idle_vec(); v.M_icode = 4'h9; step(v, 0); #1 cmp("lit_ret_stall", 64'(ifc.F_stall), 64'd1);
    v = idle_vec(); v.W_icode = 4'h9; v.W_valM = 64'h2A;
    step(v, 0); #1 cmp("lit_ret_pc", ifc.pc, 64'h2A);
    // halt: drain, then W_stat HLT
    v = idle_vec(); v.f_icode = 4'h0; v.f_valp = 64'h77; step(v, 0);
    step(idle_vec(), 0); #1 cmp("lit_drain", 64'({ifc.F_stall, ifc.D_bubble}), 64'd3);
    v = idle_vec(); v.W_stat = 2'd1; step(v, 0);
    v = idle_vec(); v.f_valp = 64'h555; step(v, 0); #1 cmp("lit_halted", 64'(ifc.halted), 64'd1);
    v = idle_vec(); v.f_valp = 64'h666; step(v, 0);
    // wrong-path halt
    step(idle_vec(), 1);
    v = idle_vec(); v.f_icode = 4'h0; step(v, 0);
    v = idle_vec(); v.E_icode = 4'h7; v.e_cnd = 1'b0; step(v, 0);
    v = idle_vec(); v.M_icode = 4'h7; v.M_cnd = 1'b0; v.M_valA = 64'h300;
    step(v, 0); #1 cmp("lit_wrongpath_pc", ifc.pc, 64'h300);
    v = idle_vec(); v.f_valp = 64'h303; step(v, 0); #1 cmp("lit_wrongpath_run", 64'(ifc.F_stall), 64'd0);

    // randomized pipeline status with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(rand_vec(), $urandom_range(0, 59) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Fetch-stage sequencer and pipeline hazard controller for the pipelined Y86-64 core.
- Owns the predicted-PC register and selects the PC presented to `fetch` each cycle.
- Predicts the next PC from the fetch outputs and generates stall/bubble controls for the F/D/E pipeline registers.
- Runs the processor status state machine (RUN / DRAIN / HALT).
- Sits between `fetch` and the pipeline-register bank; has no datapath of its own beyond PC muxing.

## Interface
- `RESET_PC`, 64'h0, PC value loaded into the predicted-PC register on reset.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `f_icode` in 4: icode from `fetch`.
- `f_valc`, `f_valp` in 64 each: valC and valP from `fetch`.
- `f_instr_valid`, `f_error` in 1 each: fetch validity and imem error.
- `d_srcA`, `d_srcB` in 4 each: decode-stage source register IDs (4'hF = none).
- `D_icode`, `E_icode`, `M_icode`, `W_icode` in 4 each: icode held in each pipeline register.
- `E_dstM` in 4: load destination in E.
- `e_cnd` in 1: condition result computed in execute.
- `M_cnd` in 1: condition latched into M.
- `M_valA` in 64: fall-through PC carried by a jump in M.
- `W_valM` in 64: return address read by `ret` in W.
- `W_stat` in 2: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- `pc` out 64: PC driven to `fetch`.
- `F_stall` out 1.
- `D_stall` out 1.
- `D_bubble` out 1.
- `E_bubble` out 1.
- `halted` out 1: high in HALT.
- `cyc_cnt`, `stall_cnt`, `mispred_cnt` out 32 each: performance counters (see Configuration).

## Operation
- **PC select**, in priority order:
  - `M_icode==7 && !M_cnd` → `M_valA`.
  - Otherwise `W_icode==9` → `W_valM`.
  - Otherwise `pred_pc_q`.
- **Prediction:** `f_icode` 7 (jXX) or 8 (call) → `f_valc`; anything else → `f_valp`.
  - `pred_pc_q` loads the prediction on each clock edge with `!F_stall`.
- **Hazard terms:**
  - `load_use = E_icode∈{5,B} && E_dstM!=F && E_dstM∈{d_srcA,d_srcB}`.
  - `ret_p = 9∈{D_icode,E_icode,M_icode}`.
  - `mispred = E_icode==7 && !e_cnd`.
- **Control outputs:**
  - `F_stall = load_use | ret_p | state!=RUN`.
  - `D_stall = load_use`.
  - `D_bubble = mispred | (ret_p & !load_use) | (state==DRAIN & !load_use)`.
  - `E_bubble = mispred | load_use`.
- **fstop condition:** `f_icode==0 | !f_instr_valid | f_error`.
- **FSM transitions:**
  - RUN → DRAIN when fstop holds with `!F_stall && !mispred`. The halting instruction enters D on that edge; DRAIN then bubbles D so exactly one copy proceeds.
  - DRAIN → RUN on `mispred`: the stop instruction was on the wrong path. `pred_pc_q` is unchanged, so the next PC comes from the `M_valA` select one cycle later.
  - RUN/DRAIN → HALT when `W_stat!=0`. This takes priority over all other transitions and also covers data-memory ADR faults.
  - HALT is terminal until reset. In HALT, `F_stall=1`, `D_stall=1`, `E_bubble=1`, `D_bubble=0`.
- **Reset (async assert):** `pred_pc_q=RESET_PC`, state RUN, `halted=0`, counters 0.
  - Stall/bubble outputs follow the combinational equations with state RUN.
  - Reset asserted mid-instruction discards all state immediately.

## Timing
- `pc` and all stall/bubble outputs are combinational from inputs and registered state, valid within the same cycle.
- Registered elements: `pred_pc_q`, state, and the counters.
- Load-use costs 1 bubble; mispredict costs 2 bubbles; `ret` costs 3 bubbles.
- `halted` rises on the clock edge after the cycle in which `W_stat!=0` is first seen.
- When `load_use` and `mispred` are simultaneous, the mispredict wins in D (`D_bubble=1` overrides `D_stall`) and E is bubbled.

## Configuration
- **`PC_CTRL_PERF_EN` defined:** counters are implemented.
  - `cyc_cnt` increments every cycle outside HALT.
  - `stall_cnt` increments on cycles with `F_stall` outside HALT.
  - `mispred_cnt` increments on `mispred` cycles.
  - All three saturate at 32'hFFFF_FFFF.
- **Not defined:** counter ports remain present and are tied to 0, and no counter flops are instantiated.

## Test plan
- **Reset with `RESET_PC`=64'h100:** after `rst_n` rises → `pc`=64'h100. A nop fetch (`f_valp`=64'h101) → `pc`=64'h101 next cycle.
- **Taken jXX:** `f_icode`=7, `f_valc`=64'h40 → next `pc`=64'h40. Then `E_icode`=7, `e_cnd`=0 → `D_bubble`=`E_bubble`=1. With `M_icode`=7, `M_cnd`=0, `M_valA`=64'h109 on the following cycle → `pc`=64'h109; `mispred_cnt`=1 with PERF on.
- **Load-use:** `E_icode`=5, `E_dstM`=3, `d_srcA`=3 → `F_stall`=`D_stall`=`E_bubble`=1 for one cycle only.
- **Ret:** `D_icode`=9, then propagated to E and M → `F_stall`=1 for 3 cycles. With `W_icode`=9, `W_valM`=64'h2A → `pc`=64'h2A.
- **Halt:** `f_icode`=0 → DRAIN with `F_stall`=1 and `D_bubble`=1. Then `W_stat`=1 → `halted`=1 the next cycle and `pc` is frozen.
- **Wrong-path halt:** DRAIN entered and `mispred`=1 the next cycle → back to RUN, and `pc` follows `M_valA` one cycle later.
